// File: rtl/video_timing_pkg.sv
// Shared types for the raster timing generator: axis phases, phase-length
// bundle and the total-length helper.
package video_timing_pkg;

   typedef enum logic [1:0] {
      PH_ACT  = 2'd0,
      PH_FP   = 2'd1,
      PH_SYNC = 2'd2,
      PH_BP   = 2'd3
   } phase_t;

   typedef struct packed {
      logic [15:0] active;
      logic [15:0] front;
      logic [15:0] sync;
      logic [15:0] back;
   } phase_len_t;

   function automatic int total_len(input phase_len_t l);
      return int'(l.active) + int'(l.front) + int'(l.sync) + int'(l.back);
   endfunction

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: ACT/FP/SYNC/BP phase FSM with a per-phase down-counter
// and a position counter; wrap pulses on the step that leaves BP.
module timing_axis
   import video_timing_pkg::*;
#(
   parameter int CW         = 10,
   parameter int RST_ACTIVE = 640
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          step,
   input  phase_len_t    len,
   output phase_t        phase,
   output logic [CW-1:0] pos,
   output logic          wrap
);

   phase_t        phase_r;
   phase_t        next_phase_s;
   logic [15:0]   dcnt_r;
   logic [15:0]   next_len_s;
   logic [CW-1:0] pos_r;
   logic          last_s;

   assign last_s = (dcnt_r == 16'd1);
   assign wrap   = step && last_s && (phase_r == PH_BP);
   assign phase  = phase_r;
   assign pos    = pos_r;

   // Successor phase and the length it is loaded with.
   always_comb begin
      next_phase_s = PH_ACT;
      next_len_s   = len.active;
      case (phase_r)
         PH_ACT: begin
            next_phase_s = PH_FP;
            next_len_s   = len.front;
         end
         PH_FP: begin
            next_phase_s = PH_SYNC;
            next_len_s   = len.sync;
         end
         PH_SYNC: begin
            next_phase_s = PH_BP;
            next_len_s   = len.back;
         end
         PH_BP: begin
            next_phase_s = PH_ACT;
            next_len_s   = len.active;
         end
         default: begin
            next_phase_s = PH_ACT;
            next_len_s   = len.active;
         end
      endcase
   end

   // Phase, down-counter and position advance together on each step.
   always_ff @(posedge clk) begin
      if (reset) begin
         phase_r <= PH_ACT;
         dcnt_r  <= 16'(RST_ACTIVE);
         pos_r   <= {CW{1'b0}};
      end else if (step) begin
         if (last_s) begin
            phase_r <= next_phase_s;
            dcnt_r  <= next_len_s;
         end else begin
            dcnt_r  <= dcnt_r - 16'd1;
         end
         pos_r <= wrap ? {CW{1'b0}} : pos_r + CW'(1'b1);
      end
   end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: coordinates, blanking, syncs and line/frame strobes.
// Optional runtime geometry via VIDEO_TIMING_SHADOW_EN.
module video_timing_gen
   import video_timing_pkg::*;
#(
   parameter int   H_ACTIVE  = 640,
   parameter int   H_FRONT   = 16,
   parameter int   H_SYNC    = 96,
   parameter int   H_BACK    = 48,
   parameter int   V_ACTIVE  = 480,
   parameter int   V_FRONT   = 10,
   parameter int   V_SYNC    = 2,
   parameter int   V_BACK    = 33,
   parameter logic HSYNC_POL = 1'b0,
   parameter logic VSYNC_POL = 1'b0,
   parameter int   XBITS     = $clog2(H_ACTIVE),
   parameter int   YBITS     = $clog2(V_ACTIVE)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
`ifdef VIDEO_TIMING_SHADOW_EN
   input  logic [4*16-1:0]  cfg_h,
   input  logic [4*16-1:0]  cfg_v,
   input  logic             cfg_valid,
`endif
   output logic [XBITS-1:0] x,
   output logic [YBITS-1:0] y,
   output logic             active,
   output logic             hsync,
   output logic             vsync,
   output logic             line_start,
   output logic             frame_start
);

   localparam phase_len_t H_PARAM = '{active: 16'(H_ACTIVE), front: 16'(H_FRONT),
                                      sync: 16'(H_SYNC), back: 16'(H_BACK)};
   localparam phase_len_t V_PARAM = '{active: 16'(V_ACTIVE), front: 16'(V_FRONT),
                                      sync: 16'(V_SYNC), back: 16'(V_BACK)};
   localparam int HCW = $clog2(total_len(H_PARAM));
   localparam int VCW = $clog2(total_len(V_PARAM));

   if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
       V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_bad_len
      $error("video_timing_gen: every phase length must be at least 1");
   end

   phase_t           h_phase_s;
   phase_t           v_phase_s;
   logic [HCW-1:0]   hcnt_s;
   logic [VCW-1:0]   vcnt_s;
   logic             h_wrap_s;
   logic             v_wrap_s;
   phase_len_t       h_len_s;
   phase_len_t       v_len_s;
   logic             h_act_s;
   logic             v_act_s;

`ifdef VIDEO_TIMING_SHADOW_EN
   phase_len_t h_shadow_r;
   phase_len_t v_shadow_r;
   phase_len_t h_pend_r;
   phase_len_t v_pend_r;
   logic       pend_r;
   logic       apply_s;

   // Pending geometry goes live on the step that wraps into pixel (0,0), so
   // the new active length is already loaded for the first line of the frame.
   assign apply_s = h_wrap_s && v_wrap_s && pend_r;
   assign h_len_s = apply_s ? h_pend_r : h_shadow_r;
   assign v_len_s = apply_s ? v_pend_r : v_shadow_r;

   // Capture pending config and promote it at the frame boundary.
   always_ff @(posedge clk) begin
      if (reset) begin
         h_shadow_r <= H_PARAM;
         v_shadow_r <= V_PARAM;
         h_pend_r   <= H_PARAM;
         v_pend_r   <= V_PARAM;
         pend_r     <= 1'b0;
      end else begin
         if (cfg_valid) begin
            h_pend_r <= '{active: cfg_h[15:0], front: cfg_h[31:16],
                          sync: cfg_h[47:32], back: cfg_h[63:48]};
            v_pend_r <= '{active: cfg_v[15:0], front: cfg_v[31:16],
                          sync: cfg_v[47:32], back: cfg_v[63:48]};
            pend_r   <= 1'b1;
         end else if (apply_s) begin
            pend_r   <= 1'b0;
         end
         if (apply_s) begin
            h_shadow_r <= h_pend_r;
            v_shadow_r <= v_pend_r;
         end
      end
   end
`else
   assign h_len_s = H_PARAM;
   assign v_len_s = V_PARAM;
`endif

   timing_axis #(.CW(HCW), .RST_ACTIVE(H_ACTIVE)) u_h_axis (
      .clk   (clk),
      .reset (reset),
      .step  (enable),
      .len   (h_len_s),
      .phase (h_phase_s),
      .pos   (hcnt_s),
      .wrap  (h_wrap_s)
   );

   timing_axis #(.CW(VCW), .RST_ACTIVE(V_ACTIVE)) u_v_axis (
      .clk   (clk),
      .reset (reset),
      .step  (h_wrap_s),
      .len   (v_len_s),
      .phase (v_phase_s),
      .pos   (vcnt_s),
      .wrap  (v_wrap_s)
   );

   assign h_act_s = (h_phase_s == PH_ACT);
   assign v_act_s = (v_phase_s == PH_ACT);

   // Outputs lag the position by one enabled step and hold while enable is low.
   always_ff @(posedge clk) begin
      if (reset) begin
         x           <= {XBITS{1'b0}};
         y           <= {YBITS{1'b0}};
         active      <= 1'b0;
         hsync       <= ~HSYNC_POL;
         vsync       <= ~VSYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (enable) begin
         x           <= h_act_s ? XBITS'(hcnt_s) : {XBITS{1'b0}};
         y           <= v_act_s ? YBITS'(vcnt_s) : y;
         active      <= h_act_s && v_act_s;
         hsync       <= (h_phase_s == PH_SYNC) ? HSYNC_POL : ~HSYNC_POL;
         vsync       <= (v_phase_s == PH_SYNC) ? VSYNC_POL : ~VSYNC_POL;
         line_start  <= h_act_s && (hcnt_s == {HCW{1'b0}});
         frame_start <= h_act_s && v_act_s && (hcnt_s == {HCW{1'b0}}) &&
                        (vcnt_s == {VCW{1'b0}});
      end
   end

endmodule

// File: tb/tb_video_timing_gen.sv
// Directed bench for video_timing_gen on a tiny 8x6 raster (H 4/1/2/1, V 3/1/1/1),
// with a second instance at inverted sync polarity.
module tb_video_timing_gen;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] x_a, y_a, x_b, y_b;
   logic       act_a, hs_a, vs_a, ls_a, fs_a;
   logic       act_b, hs_b, vs_b, ls_b, fs_b;
   int         vectors = 0;
   int         miscompares = 0;
   int         n;

   always #5 clk = ~clk;

   video_timing_gen #(
      .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
   ) dut_a (
      .clk(clk), .reset(reset), .enable(enable),
      .x(x_a), .y(y_a), .active(act_a), .hsync(hs_a), .vsync(vs_a),
      .line_start(ls_a), .frame_start(fs_a)
   );

   video_timing_gen #(
      .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
      .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
      .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
   ) dut_b (
      .clk(clk), .reset(reset), .enable(enable),
      .x(x_b), .y(y_b), .active(act_b), .hsync(hs_b), .vsync(vs_b),
      .line_start(ls_b), .frame_start(fs_b)
   );

   // Expected {x,y,active,hsync,vsync,line_start,frame_start} after k enabled steps.
   function automatic logic [8:0] exp_at(input int k, input logic hp, input logic vp);
      int p, h, v;
      logic [1:0] ex, ey;
      logic ea, ehs, evs, els, efs;
      if (k == 0) return {2'd0, 2'd0, 1'b0, ~hp, ~vp, 1'b0, 1'b0};
      p   = (k - 1) % 48;
      h   = p % 8;
      v   = p / 8;
      ex  = (h < 4) ? 2'(h) : 2'd0;
      ey  = (v < 3) ? 2'(v) : 2'd2;
      ea  = (h < 4) && (v < 3);
      ehs = (h == 5 || h == 6) ? hp : ~hp;
      evs = (v == 4) ? vp : ~vp;
      els = (h == 0);
      efs = (h == 0) && (v == 0);
      return {ex, ey, ea, ehs, evs, els, efs};
   endfunction

   task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %b expected %b", tag, obs, expv);
      end
   endtask

   task automatic check_both(input string tag, input int k);
      check({tag, "/a"}, {x_a, y_a, act_a, hs_a, vs_a, ls_a, fs_a}, exp_at(k, 1'b0, 1'b0));
      check({tag, "/b"}, {x_b, y_b, act_b, hs_b, vs_b, ls_b, fs_b}, exp_at(k, 1'b1, 1'b1));
   endtask

   initial begin
      reset  = 1'b1;
      enable = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      check_both("reset_state", 0);

      // Free-running: more than two full frames so the 48-step repeat is seen.
      reset  = 1'b0;
      enable = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         n++;
         check_both($sformatf("run_step%0d", n), n);
      end

      // Enable toggling: outputs and strobes hold on disabled cycles.
      reset = 1'b1;
      enable = 1'b0;
      @(posedge clk); #1;
      check_both("reset_again", 0);
      reset = 1'b0;
      n = 0;
      for (int c = 0; c < 200; c++) begin
         enable = (c % 2 == 0);
         @(posedge clk); #1;
         if (enable) n++;
         check_both($sformatf("toggle_cyc%0d", c), n);
      end

      // Mid-frame reset with enable low wins over the held state.
      reset = 1'b1;
      enable = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      enable = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
      end
      check_both("at_x3_y2", 20);
      reset = 1'b1;
      enable = 1'b0;
      @(posedge clk); #1;
      check_both("midframe_reset", 0);
      reset = 1'b0;
      enable = 1'b1;
      @(posedge clk); #1;
      check_both("after_reset_first", 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
